// File: rtl/tawas_raccoon_bridge_if.sv
// Signal bundle between the load/store stage, the Raccoon peripheral bus and the
// register-file writeback port; the bridge takes the slave view.
interface tawas_raccoon_bridge_if;
  logic        raccoon_cs;
  logic [31:0] daddr;
  logic        dwr;
  logic [3:0]  dmask;
  logic [31:0] dout;
  logic [3:0]  writeback_reg;
  logic        raccoon_full;

  logic        rc_req;
  logic [31:0] rc_addr;
  logic        rc_wr;
  logic [3:0]  rc_mask;
  logic [31:0] rc_wdata;
  logic        rc_ack;
  logic        rc_rvld;
  logic [31:0] rc_rdata;

  logic        rc_load_vld;
  logic [3:0]  rc_load_sel;
  logic [31:0] rc_load;
  logic        rc_err;

  modport slave (
    input  raccoon_cs, daddr, dwr, dmask, dout, writeback_reg,
    input  rc_ack, rc_rvld, rc_rdata,
    output raccoon_full, rc_req, rc_addr, rc_wr, rc_mask, rc_wdata,
    output rc_load_vld, rc_load_sel, rc_load, rc_err
  );

  modport master (
    output raccoon_cs, daddr, dwr, dmask, dout, writeback_reg,
    output rc_ack, rc_rvld, rc_rdata,
    input  raccoon_full, rc_req, rc_addr, rc_wr, rc_mask, rc_wdata,
    input  rc_load_vld, rc_load_sel, rc_load, rc_err
  );
endinterface

// File: rtl/tawas_raccoon_bridge.sv
// Buffers Raccoon-space loads/stores in a FIFO and replays them on the Raccoon bus.
// Optional REQ/WAIT watchdog: define TAWAS_RACCOON_TIMEOUT_EN.
module tawas_raccoon_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  tawas_raccoon_bridge_if.slave  io_bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  rd;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  entry_t        r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state, w_state_next;

  logic          r_req, r_wr, r_load_vld, r_err;
  logic [31:0]   r_addr, r_wdata, r_load;
  logic [3:0]    r_mask, r_rd, r_load_sel;

  logic          w_full, w_push, w_ovf, w_pop, w_tmo, w_tmo_err, w_rvld_take;
  entry_t        w_head, w_entry;

  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [3:0] m);
    case (m)
      4'b1100: return {16'h0, d[31:16]};
      4'b0011: return {16'h0, d[15:0]};
      4'b1000: return {24'h0, d[31:24]};
      4'b0100: return {24'h0, d[23:16]};
      4'b0010: return {24'h0, d[15:8]};
      4'b0001: return {24'h0, d[7:0]};
      default: return d;
    endcase
  endfunction

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_push  = io_bus.raccoon_cs & ~w_full;
  assign w_ovf   = io_bus.raccoon_cs & w_full;
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
  assign w_head  = r_mem[r_rptr];
  assign w_entry = '{addr: io_bus.daddr, wr: io_bus.dwr, mask: io_bus.dmask,
                     data: io_bus.dout, rd: io_bus.writeback_reg};
  assign w_rvld_take = (r_state == S_WAIT) && io_bus.rc_rvld;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef TAWAS_RACCOON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  assign w_tmo = (r_tmo_cnt == TW'(TIMEOUT));

  // Restarts on every state change, so entry into REQ and into WAIT both clear it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                    r_tmo_cnt <= '0;
    else if (w_state_next != r_state)                r_tmo_cnt <= '0;
    else if (r_state == S_REQ || r_state == S_WAIT)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tmo_err    = 1'b0;
    case (r_state)
      S_IDLE: if (r_count != '0) w_state_next = S_REQ;
      S_REQ: begin
        if (io_bus.rc_ack) begin
          w_state_next = r_wr ? S_IDLE : S_WAIT;
        end else if (w_tmo) begin
          w_tmo_err    = 1'b1;
          w_state_next = r_wr ? S_IDLE : S_WB;
        end
      end
      S_WAIT: begin
        if (io_bus.rc_rvld) begin
          w_state_next = S_WB;
        end else if (w_tmo) begin
          w_tmo_err    = 1'b1;
          w_state_next = S_WB;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req      <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_load     <= '0;
      r_load_sel <= '0;
      r_load_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= w_ovf | w_tmo_err;
      r_load_vld <= (w_state_next == S_WB);
      if (w_pop) begin
        r_req   <= 1'b1;
        r_addr  <= w_head.addr;
        r_wr    <= w_head.wr;
        r_mask  <= w_head.mask;
        r_wdata <= w_head.data;
        r_rd    <= w_head.rd;
      end else if (r_state == S_REQ && w_state_next != S_REQ) begin
        r_req <= 1'b0;
      end
      // Aborted loads still write back, with all-ones as the poison value.
      if (w_state_next == S_WB) begin
        r_load     <= w_rvld_take ? f_extract(io_bus.rc_rdata, r_mask) : 32'hFFFF_FFFF;
        r_load_sel <= r_rd;
      end
    end
  end

  assign io_bus.raccoon_full = (r_count >= CW'(FIFO_DEPTH - 1));
  assign io_bus.rc_req       = r_req;
  assign io_bus.rc_addr      = r_addr;
  assign io_bus.rc_wr        = r_wr;
  assign io_bus.rc_mask      = r_mask;
  assign io_bus.rc_wdata     = r_wdata;
  assign io_bus.rc_load_vld  = r_load_vld;
  assign io_bus.rc_load_sel  = r_load_sel;
  assign io_bus.rc_load      = r_load;
  assign io_bus.rc_err       = r_err;
endmodule
